// File: rtl/dmem_req_queue.sv
// Data-memory request queue: buffers core load/store requests in a circular FIFO
// and issues them one at a time to memory through a three-state handshake FSM.
module dmem_req_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wen,
  input  logic                       req_byte,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       resp_valid,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       mem_valid_o,
  output logic                       mem_wen_o,
  output logic                       mem_byte_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  input  logic                       mem_yumi_i,
  input  logic                       mem_valid_i,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  output logic                       mem_yumi_o,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    DMEM_IDLE      = 2'd0,
    DMEM_REQ_SENT  = 2'd1,
    DMEM_REQ_ACKED = 2'd2
  } dmemState_e;

  dmemState_e stateR, stateS;

  logic              wenMem   [DEPTH];
  logic              byteMem  [DEPTH];
  logic [ADDR_W-1:0] addrMem  [DEPTH];
  logic [DATA_W-1:0] wdataMem [DEPTH];

  logic [PW-1:0]     wrPtrR, rdPtrR;
  logic [CW-1:0]     countR;
  logic              errR;
  logic              postRstR;
  logic              ldByteR;
  logic              respValidR;
  logic [DATA_W-1:0] respRdataR;

  logic pushS, popS, sentS, captureS;

  assign req_ready = n_reset && (countR != FULL_COUNT);
  assign pushS     = req_valid && req_ready;
  assign sentS     = n_reset && (stateR == DMEM_REQ_SENT);
  assign popS      = sentS && mem_yumi_i;
  assign captureS  = n_reset && (stateR == DMEM_REQ_ACKED) && mem_valid_i;

  assign mem_valid_o = sentS;
  assign mem_yumi_o  = captureS;
  // Command fields read as zero whenever no command is presented.
  assign mem_wen_o   = sentS ? wenMem[rdPtrR]   : 1'b0;
  assign mem_byte_o  = sentS ? byteMem[rdPtrR]  : 1'b0;
  assign mem_addr_o  = sentS ? addrMem[rdPtrR]  : {ADDR_W{1'b0}};
  assign mem_wdata_o = sentS ? wdataMem[rdPtrR] : {DATA_W{1'b0}};

  assign count      = countR;
  assign err        = errR;
  assign resp_valid = respValidR;
  assign resp_rdata = respRdataR;

  // FIFO storage; a reset flushes entries through the pointers, not the data.
  always_ff @(posedge clk) begin
    if (pushS) begin
      wenMem[wrPtrR]   <= req_wen;
      byteMem[wrPtrR]  <= req_byte;
      addrMem[wrPtrR]  <= req_addr;
      wdataMem[wrPtrR] <= req_wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wrPtrR <= {PW{1'b0}};
      rdPtrR <= {PW{1'b0}};
      countR <= {CW{1'b0}};
    end else begin
      if (pushS) wrPtrR <= wrPtrR + PW'(1);
      if (popS)  rdPtrR <= rdPtrR + PW'(1);
      case ({pushS, popS})
        2'b10:   countR <= countR + CW'(1);
        2'b01:   countR <= countR - CW'(1);
        default: countR <= countR;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_reset) stateR <= DMEM_IDLE;
    else          stateR <= stateS;
  end

  // FSM next-state logic.
  always_comb begin
    stateS = stateR;
    case (stateR)
      DMEM_IDLE: begin
        if (countR != {CW{1'b0}}) stateS = DMEM_REQ_SENT;
        else                      stateS = DMEM_IDLE;
      end
      DMEM_REQ_SENT: begin
        if (mem_yumi_i) stateS = wenMem[rdPtrR] ? DMEM_IDLE : DMEM_REQ_ACKED;
        else            stateS = DMEM_REQ_SENT;
      end
      DMEM_REQ_ACKED: begin
        if (mem_valid_i) stateS = DMEM_IDLE;
        else             stateS = DMEM_REQ_ACKED;
      end
      default: stateS = DMEM_IDLE;
    endcase
  end

  // Load response path: remember the access size at issue, zero-extend bytes at capture.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ldByteR    <= 1'b0;
      respValidR <= 1'b0;
      respRdataR <= {DATA_W{1'b0}};
    end else begin
      if (popS) ldByteR <= byteMem[rdPtrR];
      respValidR <= captureS;
      if (captureS) begin
        if (ldByteR) respRdataR <= {{(DATA_W-8){1'b0}}, mem_rdata_i[7:0]};
        else         respRdataR <= mem_rdata_i;
      end
    end
  end

  // Sticky error on stray read data; a late response on the first edge after reset is forgiven.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      errR     <= 1'b0;
      postRstR <= 1'b1;
    end else begin
      postRstR <= 1'b0;
      if (mem_valid_i && (stateR != DMEM_REQ_ACKED) && !postRstR) errR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_req_queue.sv
// Directed self-checking bench for dmem_req_queue: loads, byte zero-extension,
// full-queue back-pressure, back-to-back stores, stray-data error and mid-load reset.
module tb_dmem_req_queue;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid, req_ready, req_wen, req_byte;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_valid_o, mem_wen_o, mem_byte_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_yumi_i, mem_valid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_yumi_o;
  logic [2:0]  count;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  dmem_req_queue #(.DATA_W(32), .ADDR_W(12), .DEPTH(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_yumi_i(mem_yumi_i), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .mem_yumi_o(mem_yumi_o), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic wen, input logic bt, input logic [11:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_wen = wen; req_byte = bt; req_addr = addr; req_wdata = wd;
  endtask

  initial begin
    n_reset = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_byte = 1'b0;
    req_addr = 12'h000; req_wdata = 32'h0;
    mem_yumi_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = 32'h0;
    tick(); tick();
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_mvalid", mem_valid_o, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_resp", resp_valid, 1'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_maddr", mem_addr_o, 12'h000);
    n_reset = 1'b1;
    #1 chk("ready_after_rst", req_ready, 1'b1);

    // Word load of 0x010, data returned two cycles after acceptance.
    offer(1'b0, 1'b0, 12'h010, 32'h0);
    tick(); req_valid = 1'b0;
    chk("wl_count1", count, 3'd1);
    chk("wl_no_bypass", mem_valid_o, 1'b0);
    tick();
    chk("wl_mvalid", mem_valid_o, 1'b1);
    chk("wl_maddr", mem_addr_o, 12'h010);
    chk("wl_mwen", mem_wen_o, 1'b0);
    mem_yumi_i = 1'b1;
    tick(); mem_yumi_i = 1'b0;
    chk("wl_one_outst", mem_valid_o, 1'b0);
    chk("wl_count0", count, 3'd0);
    tick();
    chk("wl_yumo_idle", mem_yumi_o, 1'b0);
    mem_valid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1 chk("wl_yumo", mem_yumi_o, 1'b1);
    tick(); mem_valid_i = 1'b0;
    chk("wl_resp", resp_valid, 1'b1);
    chk("wl_rdata", resp_rdata, 32'hDEADBEEF);
    tick();
    chk("wl_resp_pulse", resp_valid, 1'b0);
    chk("wl_err", err, 1'b0);

    // Byte load zero-extends the low byte.
    offer(1'b0, 1'b1, 12'h021, 32'h0);
    tick(); req_valid = 1'b0;
    tick();
    chk("bl_mbyte", mem_byte_o, 1'b1);
    chk("bl_maddr", mem_addr_o, 12'h021);
    mem_yumi_i = 1'b1;
    tick(); mem_yumi_i = 1'b0;
    mem_valid_i = 1'b1; mem_rdata_i = 32'h123456A5;
    tick(); mem_valid_i = 1'b0;
    chk("bl_resp", resp_valid, 1'b1);
    chk("bl_rdata", resp_rdata, 32'h000000A5);
    tick();

    // Five stores offered with memory stalled: only four fit.
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 1'b0, 12'h100 + 12'(i), 32'hA0 + 32'(i));
      #1 chk("full_ready", req_ready, (i < 4) ? 1'b1 : 1'b0);
      tick();
    end
    req_valid = 1'b0;
    chk("full_count", count, 3'd4);
    chk("full_ready_end", req_ready, 1'b0);
    mem_yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_mvalid", mem_valid_o, 1'b1);
      chk("drain_addr", mem_addr_o, 12'h100 + 12'(k));
      chk("drain_wdata", mem_wdata_o, 32'hA0 + 32'(k));
      tick();
      chk("drain_count", count, 3'(3 - k));
      tick();
    end
    mem_yumi_i = 1'b0;
    chk("drain_empty", count, 3'd0);
    chk("drain_idle", mem_valid_o, 1'b0);

    // Back-to-back SW 0x004 then SB 0x005 with memory always accepting.
    mem_yumi_i = 1'b1;
    offer(1'b1, 1'b0, 12'h004, 32'h11223344);
    tick();
    offer(1'b1, 1'b1, 12'h005, 32'h000000CC);
    tick(); req_valid = 1'b0;
    chk("st1_addr", mem_addr_o, 12'h004);
    chk("st1_wen", mem_wen_o, 1'b1);
    chk("st1_byte", mem_byte_o, 1'b0);
    chk("st1_wdata", mem_wdata_o, 32'h11223344);
    tick();
    chk("st_gap", mem_valid_o, 1'b0);
    chk("st_count1", count, 3'd1);
    tick();
    chk("st2_addr", mem_addr_o, 12'h005);
    chk("st2_byte", mem_byte_o, 1'b1);
    chk("st2_wdata", mem_wdata_o, 32'h000000CC);
    tick();
    chk("st_count0", count, 3'd0);
    chk("st_noresp", resp_valid, 1'b0);
    tick();
    chk("st_idle", mem_valid_o, 1'b0);
    chk("st_noresp2", resp_valid, 1'b0);
    mem_yumi_i = 1'b0;

    // Stray read data while idle sets the sticky error.
    mem_valid_i = 1'b1; mem_rdata_i = 32'h00000BAD;
    #1 chk("stray_yumo", mem_yumi_o, 1'b0);
    tick(); mem_valid_i = 1'b0;
    chk("stray_err", err, 1'b1);
    chk("stray_resp", resp_valid, 1'b0);
    chk("stray_count", count, 3'd0);
    tick();
    chk("stray_idle", mem_valid_o, 1'b0);

    // Fill with four loads, accept the head so three remain queued in REQ_ACKED.
    for (int i = 0; i < 4; i++) begin
      offer(1'b0, 1'b0, 12'h030 + 12'(i), 32'h0);
      tick();
    end
    req_valid = 1'b0;
    chk("acc_addr", mem_addr_o, 12'h030);
    chk("err_sticky", err, 1'b1);
    mem_yumi_i = 1'b1;
    tick(); mem_yumi_i = 1'b0;
    chk("acc_count", count, 3'd3);
    chk("acc_mvalid", mem_valid_o, 1'b0);

    // Reset mid-load, then a late response on the first post-reset edge.
    n_reset = 1'b0;
    tick();
    chk("mr_count", count, 3'd0);
    chk("mr_mvalid", mem_valid_o, 1'b0);
    chk("mr_ready", req_ready, 1'b0);
    chk("mr_err", err, 1'b0);
    chk("mr_rdata", resp_rdata, 32'h0);
    n_reset = 1'b1;
    mem_valid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    #1 chk("late_yumo", mem_yumi_o, 1'b0);
    tick(); mem_valid_i = 1'b0;
    chk("late_err", err, 1'b0);
    chk("late_resp", resp_valid, 1'b0);
    chk("late_count", count, 3'd0);
    tick();
    chk("late_idle", mem_valid_o, 1'b0);
    chk("late_resp2", resp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
